// File: rtl/matrix_result_collector.sv
// matrix_result_collector: captures the multiplier's byte-serial result matrix after done,
// keeps a running checksum and holds the matrix for registered random-access readback until ack.
module matrix_result_collector #(
    parameter int ROWS   = 3,
    parameter int COLS   = 3,
    parameter int DATA_W = 8,
    parameter int AW     = 4,
    parameter int SUM_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              done_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              ack,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              result_valid,
    output logic              busy,
    output logic              overrun,
    output logic [SUM_W-1:0]  sum
);
    localparam int N = ROWS * COLS;

    typedef enum logic [1:0] {IDLE, CAPTURE, HOLD} state_t;

    state_t            state;
    logic [AW-1:0]     count;
    logic [DATA_W-1:0] mem [N];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            count        <= '0;
            sum          <= '0;
            rd_data      <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            for (int i = 0; i < N; i++) mem[i] <= '0;
        end else begin
            rd_data <= (int'(rd_addr) < N) ? mem[rd_addr] : '0;
            case (state)
                IDLE: if (done_in) begin
                    state <= CAPTURE;
                    busy  <= 1'b1;
                    count <= '0;
                    sum   <= '0;
                end
                CAPTURE: begin
                    mem[count] <= data_in;
                    sum        <= sum + SUM_W'(data_in);
                    count      <= count + 1'b1;
                    if (done_in) overrun <= 1'b1;
                    if (count == AW'(N - 1)) begin
                        state        <= HOLD;
                        busy         <= 1'b0;
                        result_valid <= 1'b1;
                    end
                end
                HOLD: if (ack) begin
                    // ack together with done re-arms straight into a new capture
                    result_valid <= 1'b0;
                    count        <= '0;
                    if (done_in) begin
                        state <= CAPTURE;
                        busy  <= 1'b1;
                        sum   <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end else if (done_in) begin
                    overrun <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_result_collector.sv
// tb_matrix_result_collector: directed self-checking bench; drives and samples on the falling edge.
module tb_matrix_result_collector;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       done_in = 1'b0;
    logic [7:0] data_in = '0;
    logic       ack = 1'b0;
    logic [3:0] rd_addr = '0;
    logic [7:0] rd_data, rd_data_w8;
    logic       result_valid, busy, overrun;
    logic       result_valid_w8, busy_w8, overrun_w8;
    logic [11:0] sum;
    logic [7:0]  sum_w8;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    matrix_result_collector dut (
        .clk(clk), .rst(rst), .done_in(done_in), .data_in(data_in), .ack(ack),
        .rd_addr(rd_addr), .rd_data(rd_data), .result_valid(result_valid),
        .busy(busy), .overrun(overrun), .sum(sum)
    );

    // narrow checksum instance sees identical stimulus to exercise wraparound
    matrix_result_collector #(.SUM_W(8)) dut_w8 (
        .clk(clk), .rst(rst), .done_in(done_in), .data_in(data_in), .ack(ack),
        .rd_addr(rd_addr), .rd_data(rd_data_w8), .result_valid(result_valid_w8),
        .busy(busy_w8), .overrun(overrun_w8), .sum(sum_w8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic rd(input int addr, input int exp);
        @(negedge clk);
        rd_addr = 4'(addr);
        @(negedge clk);
        chk($sformatf("rd[%0d]", addr), rd_data, exp);
    endtask

    // done pulse then 9 elements base+k*step; noise pulses done/ack mid-capture
    task automatic send(input int base, input int step, input logic with_ack, input logic noise);
        @(negedge clk);
        done_in = 1'b1;
        ack = with_ack;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (k == 0) chk("busy_start", busy, 1);
            if (k == 0) chk("rv_low_start", result_valid, 0);
            if (k == 8) chk("rv_low_before_last", result_valid, 0);
            done_in = noise && (k == 2 || k == 5);
            ack = noise && (k == 2 || k == 5);
            data_in = 8'(base + k * step);
        end
        @(negedge clk);
        done_in = 1'b0;
        ack = 1'b0;
        chk("rv_rise", result_valid, 1);
        chk("busy_end", busy, 0);
    endtask

    initial begin
        #12;
        chk("rst_rv", result_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_sum", sum, 0);
        chk("rst_rd", rd_data, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        send(10, 3, 1'b0, 1'b0);
        chk("basic_sum", sum, 198);
        chk("basic_ovr", overrun, 0);
        for (int a = 0; a < 16; a++) rd(a, a < 9 ? 10 + 3 * a : 0);

        send(200, 1, 1'b1, 1'b0);
        chk("rearm_sum", sum, 1836);
        chk("rearm_ovr", overrun, 0);
        rd(0, 200);
        rd(8, 208);

        @(negedge clk);
        done_in = 1'b1;
        @(negedge clk);
        done_in = 1'b0;
        chk("hold_ovr", overrun, 1);
        chk("hold_rv", result_valid, 1);
        chk("hold_busy", busy, 0);
        chk("hold_sum", sum, 1836);
        rd(4, 204);

        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("ack_rv", result_valid, 0);
        chk("ack_busy", busy, 0);

        @(negedge clk);
        done_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            done_in = 1'b0;
            data_in = 8'(50 + k);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rv", result_valid, 0);
        chk("mid_rst_ovr", overrun, 0);
        chk("mid_rst_sum", sum, 0);
        chk("mid_rst_rd", rd_data, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_busy", busy, 0);
        send(100, 1, 1'b0, 1'b0);
        chk("fresh_sum", sum, 936);
        chk("fresh_ovr", overrun, 0);
        rd(3, 103);
        rd(8, 108);

        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("idle_ack_rv", result_valid, 0);
        chk("idle_ack_busy", busy, 0);
        chk("idle_ack_ovr", overrun, 0);

        send(255, 0, 1'b0, 1'b1);
        chk("noise_sum", sum, 2295);
        chk("wrap_sum_w8", sum_w8, 247);
        chk("noise_ovr", overrun, 1);
        chk("noise_rv", result_valid, 1);
        rd(0, 255);
        rd(8, 255);
        rd(9, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
